// File: rtl/mem_pkg.sv
// Shared definitions for memory-side blocks: FSM encoding and default RAM depth.
package mem_pkg;

  localparam int MEM_DEPTH_DEF = 512;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_RD_SETUP   = 3'd2,
    ST_RD_CAPTURE = 3'd3,
    ST_ACK        = 3'd4
  } state_e;

  // The RAM read strobe is held across both read states only.
  function automatic logic is_rd_state(state_e s);
    return (s == ST_RD_SETUP) || (s == ST_RD_CAPTURE);
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first requester at or above rr_ptr, wrapping.
module rr_select #(
  parameter int NUM_CORES = 4,
  parameter int ID_W      = 2
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [ID_W-1:0]      rr_ptr,
  output logic                 valid,
  output logic [ID_W-1:0]      gnt_id
);

  int idx;

  // Scan NUM_CORES slots starting at rr_ptr; the first hit wins.
  always_comb begin
    valid  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_CORES;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        gnt_id = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising per-core read/write requests onto one data RAM.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 64,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        wr,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  output logic [NUM_CORES-1:0]        ack,
  output logic                        err,
  output logic [DATA_W-1:0]           rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_wr,
  output logic                        mem_rd,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int ID_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                sel_valid;
  logic [ID_W-1:0]     sel_id;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_oob;
  logic                grant;

  rr_select #(.NUM_CORES(NUM_CORES), .ID_W(ID_W)) u_rr_select (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (sel_valid),
    .gnt_id (sel_id)
  );

  assign sel_addr = addr[int'(sel_id)*ADDR_W +: ADDR_W];
  assign sel_oob  = ({1'b0, sel_addr} >= DEPTH_EXT);
  assign grant    = (state_q == ST_IDLE) && sel_valid;

  // State and latched-request registers; reset abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Latch the winner on grant, advance the pointer, capture read data.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    if (grant) begin
      id_d     = sel_id;
      err_d    = sel_oob;
      addr_d   = sel_addr;
      wdata_d  = wdata[int'(sel_id)*DATA_W +: DATA_W];
      rr_ptr_d = (sel_id == ID_W'(NUM_CORES-1)) ? '0 : sel_id + 1'b1;
    end
    if (state_q == ST_RD_CAPTURE) rdata_d = mem_rdata;
  end

  // Next state; out-of-range requests skip the RAM and go straight to ACK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          if (sel_oob)         state_d = ST_ACK;
          else if (wr[sel_id]) state_d = ST_WRITE;
          else                 state_d = ST_RD_SETUP;
        end
      end
      ST_WRITE:      state_d = ST_ACK;
      ST_RD_SETUP:   state_d = ST_RD_CAPTURE;
      ST_RD_CAPTURE: state_d = ST_ACK;
      ST_ACK:        state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; RAM strokes are mutually exclusive by construction.
  always_comb begin
    ack = '0;
    if (state_q == ST_ACK) ack[id_q] = 1'b1;
    err       = (state_q == ST_ACK) && err_q;
    rdata     = rdata_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wr    = (state_q == ST_WRITE);
    mem_rd    = is_rd_state(state_q);
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural RAM model.
module tb_mem_arbiter;

  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     req, wr;
  logic [NC*AW-1:0]  addr;
  logic [NC*DW-1:0]  wdata;
  logic [NC-1:0]     ack;
  logic              err;
  logic [DW-1:0]     rdata;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_wr, mem_rd;
  logic [DW-1:0]     mem_rdata;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, read data registered while RD is high.
  logic [DW-1:0] mem [0:511];
  initial begin
    for (int k = 0; k < 512; k++) mem[k] = 64'hC0DE_0000_0000_0000 | 64'(k);
    mem[1] = 64'h0001_0002_0003_0004;
    mem_rdata = '0;
  end
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[8:0]] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr[8:0]];
  end

  typedef struct {
    logic [NC-1:0] ack;
    logic          err;
    logic          chk_rd;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop one expectation per ack and compare.
  always @(negedge clk) begin
    check("wr_rd_exclusive", 64'(mem_wr & mem_rd), 64'd0);
    if (ack != '0) begin
      if (sbq.size() == 0) begin
        check("unexpected_ack", 64'(ack), 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("ack", 64'(ack), 64'(mon_e.ack));
        check("err", 64'(err), 64'(mon_e.err));
        check("mem_rd_low_at_ack", 64'(mem_rd), 64'd0);
        if (mon_e.chk_rd) check("rdata", rdata, mon_e.rdata);
      end
    end
  end

  function automatic exp_t mk(input int c, input bit e_err, input bit chk, input logic [63:0] rd);
    exp_t x;
    x.ack    = 4'(1 << c);
    x.err    = e_err;
    x.chk_rd = chk;
    x.rdata  = rd;
    return x;
  endfunction

  // Issue one request from an idle DUT, measure latency and RAM strobes.
  task automatic do_txn(input int c, input bit w, input logic [15:0] a, input logic [63:0] d,
                        input bit e_err, input bit chk, input logic [63:0] e_rd, input int lat);
    int n, wrc, rdc;
    bit got;
    logic [15:0] wa;
    logic [63:0] wd;
    sbq.push_back(mk(c, e_err, chk, e_rd));
    wr[c] = w;
    addr[c*AW +: AW] = a;
    wdata[c*DW +: DW] = d;
    req[c] = 1'b1;
    n = 0; wrc = 0; rdc = 0; got = 0; wa = '0; wd = '0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_wr) begin wrc++; wa = mem_addr; wd = mem_wdata; end
      if (mem_rd) rdc++;
      if (ack[c]) got = 1;
    end
    req[c] = 1'b0;
    check("latency", 64'(n), 64'(lat));
    check("wr_cycles", 64'(wrc), (w && !e_err) ? 64'd1 : 64'd0);
    check("rd_cycles", 64'(rdc), (!w && !e_err) ? 64'd2 : 64'd0);
    if (w && !e_err) begin
      check("wr_addr", 64'(wa), 64'(a));
      check("wr_data", wd, d);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt, cyc;
    rst = 1'b1;
    req = '0; wr = '0; addr = '0; wdata = '0;
    // All four cores read from reset onward: addrs 10..13.
    for (int c = 0; c < NC; c++) addr[c*AW +: AW] = 16'(10 + c);
    req = 4'hF;
    #3;
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_mem_wr", 64'(mem_wr), 64'd0);
    check("rst_mem_rd", 64'(mem_rd), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);

    @(negedge clk); @(negedge clk);
    sbq.push_back(mk(0, 0, 1, 64'hC0DE_0000_0000_000A));
    sbq.push_back(mk(1, 0, 1, 64'hC0DE_0000_0000_000B));
    sbq.push_back(mk(2, 0, 1, 64'hC0DE_0000_0000_000C));
    sbq.push_back(mk(3, 0, 1, 64'hC0DE_0000_0000_000D));
    sbq.push_back(mk(0, 0, 1, 64'hC0DE_0000_0000_000A));
    rst = 1'b0;
    cnt = 0; cyc = 0;
    while (cnt < 5 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) cnt++;
    end
    req = '0;
    check("rr_ack_count", 64'(cnt), 64'd5);
    @(negedge clk);

    do_txn(2, 1, 16'd5,   64'hDEAD_BEEF_0000_0001, 0, 0, 64'd0, 2);
    do_txn(0, 0, 16'd1,   64'd0, 0, 1, 64'h0001_0002_0003_0004, 3);
    do_txn(3, 0, 16'd600, 64'd0, 1, 1, 64'h0001_0002_0003_0004, 1);
    do_txn(2, 0, 16'd5,   64'd0, 0, 1, 64'hDEAD_BEEF_0000_0001, 3);
    do_txn(1, 1, 16'd7,   64'h1111_2222_3333_4444, 0, 0, 64'd0, 2);
    do_txn(1, 0, 16'd7,   64'd0, 0, 1, 64'h1111_2222_3333_4444, 3);
    do_txn(0, 0, 16'd511, 64'd0, 0, 1, 64'hC0DE_0000_0000_01FF, 3);
    do_txn(3, 1, 16'd512, 64'h5555_5555_5555_5555, 1, 1, 64'hC0DE_0000_0000_01FF, 1);

    // Reset in the middle of a read: no ack for core 0, core 1 served after release.
    wr[0] = 1'b0; addr[0 +: AW] = 16'd9; req[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rd_active_before_rst", 64'(mem_rd), 64'd1);
    wr[1] = 1'b0; addr[AW +: AW] = 16'd7; req[1] = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("midrst_ack", 64'(ack), 64'd0);
    check("midrst_mem_rd", 64'(mem_rd), 64'd0);
    check("midrst_mem_addr", 64'(mem_addr), 64'd0);
    check("midrst_mem_wdata", mem_wdata, 64'd0);
    check("midrst_rdata", rdata, 64'd0);
    req[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_txn(1, 0, 16'd7, 64'd0, 0, 1, 64'h1111_2222_3333_4444, 3);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
